mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester and the data (load/store) requester.
- Sits between the IF/MEM pipeline stages and the memory interface.
- Issues one transaction at a time and remembers which requester owns the outstanding read.
- Routes the read data back through a valid/ready handshake to that owner only.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
DATA_STREAK_MAX, 4, consecutive data grants allowed while an instruction request waits; next grant goes to instruction

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
inst_req_valid  in  1  IF read request
inst_req_ready  out  1  IF request accepted this cycle
inst_addr  in  ADDR_W  IF address
inst_rdata  out  DATA_W  fetch data
inst_rdata_valid  out  1  fetch data valid
inst_rdata_ready  in  1  IF can take data
data_req_valid  in  1  load/store request
data_req_ready  out  1  data request accepted this cycle
data_we  in  1  1 = store, 0 = load
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data
data_wstrb  in  DATA_W/8  store byte strobes
data_rdata  out  DATA_W  load data
data_rdata_valid  out  1  load data valid
data_rdata_ready  in  1  MEM stage can take data
Address  out  ADDR_W  memory address (registered)
MemRead  out  1  read request valid
MemWrite  out  1  write request valid
Write_data  out  DATA_W  registered store data
Write_strb  out  DATA_W/8  registered strobes
Mem_Req_Ready  in  1  memory accepts request
Read_data  in  DATA_W  memory read data
Read_data_Valid  in  1  memory read data valid
Read_data_Ready  out  1  arbiter accepts read data

Behaviour:
- Reset: asynchronous on reset==0, effective immediately.
  - state=IDLE, owner=INST, streak=0.
  - MemRead, MemWrite, inst_req_ready, data_req_ready all 0.
  - Both rdata_valid outputs 0, Read_data_Ready 0.
  - Address/Write_data/Write_strb = 0.
  - Reset mid-transaction abandons it; no response is forwarded afterwards.
- FSM states: IDLE, RD_REQ, RD_RESP, WR_REQ.
- IDLE grant (combinational; at most one ready high per cycle):
  - Data wins if data_req_valid && !(inst_req_valid && streak==DATA_STREAK_MAX).
  - Otherwise inst wins if inst_req_valid.
  - The winner's *_req_ready=1 in IDLE; the handshake is valid && ready.
- On grant, latch into output registers: Address, Write_data, Write_strb (inst grant: strb=0), and owner.
  - Data grant with data_we=1 -> WR_REQ; otherwise -> RD_REQ.
- Streak counter:
  - Data grant while inst_req_valid: streak += 1, saturating at DATA_STREAK_MAX.
  - Inst grant: streak=0.
  - Data grant with no inst pending: streak=0.
- RD_REQ: MemRead=1. On Mem_Req_Ready -> RD_RESP, MemRead drops next cycle.
- WR_REQ: MemWrite=1. On Mem_Req_Ready -> IDLE. No write response.
- RD_RESP (read data path is combinational, no added latency):
  - inst_rdata = data_rdata = Read_data.
  - {owner}_rdata_valid = Read_data_Valid; the other valid stays 0.
  - Read_data_Ready = owner's rdata_ready.
  - On Read_data_Valid && Read_data_Ready -> IDLE.
- Outside RD_RESP: both rdata_valid=0 and Read_data_Ready=0.
- Request signals stay stable while MemRead/MemWrite are held until Mem_Req_Ready.
- Latency: request accepted in cycle N -> MemRead/MemWrite high in N+1.
  - Minimum read = 3 cycles (grant, request, response); minimum write = 2 cycles.
- Simultaneous inst and data requests in IDLE follow the grant rule. The loser keeps valid high and is not acknowledged.
- Only one outstanding transaction; no new grant until back in IDLE.

Decomposition:
- Shared package (mycpu.h): state encodings, owner encoding (OWNER_INST=0, OWNER_DATA=1).
- Single module; no sub-module needed.
- The grant/streak logic may be a small function inside the module.

Test Plan:
- Inst-only read: inst_req_valid, addr 0x100, Mem_Req_Ready=1, Read_data 0x00000013 after 1 cycle, inst_rdata_ready=1 -> inst_rdata_valid pulse with 0x00000013; data_rdata_valid stays 0.
- Simultaneous requests: inst addr 0x200, data load addr 0x1004 same cycle, streak=0 -> data granted first with Address=0x1004; inst granted after the data response; inst_req_ready stays 0 until then.
- Store: data_we=1, addr 0x2000, wdata 0xDEADBEEF, wstrb 4'b0011, Mem_Req_Ready delayed 3 cycles -> MemWrite held 3 cycles, outputs stable, then IDLE; no rdata_valid.
- Starvation cap: data and inst both valid continuously -> exactly 4 data grants, then 1 inst grant, then streak resets to 0.
- Backpressure: Read_data_Valid=1 with data_rdata_ready=0 for 2 cycles -> Read_data_Ready=0 and state stays RD_RESP; completes on the cycle ready rises.
- Async reset mid-read: reset=0 in RD_RESP -> all outputs 0 immediately; after release, a late Read_data_Valid is not forwarded.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_RESP = 2'd2,
    ST_WR_REQ  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // One-hot-or-zero grant decision for the two requesters.
  typedef struct packed {
    logic inst;
    logic data;
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF requester, MEM requester and memory-side signals of the arbiter.
// slave  : the arbiter's view (serves the pipeline stages, drives the memory request).
// master : the surrounding pipeline/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                inst_req_valid;
  logic                inst_req_ready;
  logic [ADDR_W-1:0]   inst_addr;
  logic [DATA_W-1:0]   inst_rdata;
  logic                inst_rdata_valid;
  logic                inst_rdata_ready;

  logic                data_req_valid;
  logic                data_req_ready;
  logic                data_we;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic [DATA_W/8-1:0] data_wstrb;
  logic [DATA_W-1:0]   data_rdata;
  logic                data_rdata_valid;
  logic                data_rdata_ready;

  logic [ADDR_W-1:0]   Address;
  logic                MemRead;
  logic                MemWrite;
  logic [DATA_W-1:0]   Write_data;
  logic [DATA_W/8-1:0] Write_strb;
  logic                Mem_Req_Ready;
  logic [DATA_W-1:0]   Read_data;
  logic                Read_data_Valid;
  logic                Read_data_Ready;

  modport slave (
    input  inst_req_valid, inst_addr, inst_rdata_ready,
    input  data_req_valid, data_we, data_addr, data_wdata, data_wstrb, data_rdata_ready,
    input  Mem_Req_Ready, Read_data, Read_data_Valid,
    output inst_req_ready, inst_rdata, inst_rdata_valid,
    output data_req_ready, data_rdata, data_rdata_valid,
    output Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready
  );

  modport master (
    output inst_req_valid, inst_addr, inst_rdata_ready,
    output data_req_valid, data_we, data_addr, data_wdata, data_wstrb, data_rdata_ready,
    output Mem_Req_Ready, Read_data, Read_data_Valid,
    input  inst_req_ready, inst_rdata, inst_rdata_valid,
    input  data_req_ready, data_rdata, data_rdata_valid,
    input  Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction at a time, with a cap on how long data may starve fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  io_arb
);

  localparam int            SW         = $clog2(DATA_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_CAP = SW'(DATA_STREAK_MAX);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  owner_e              r_owner;
  logic [SW-1:0]       r_streak;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  grant_t              w_gnt;
  logic                w_rd_rdy;
  logic                w_inst_rvld;
  logic                w_data_rvld;

  // Data normally wins; once it has won STREAK_CAP times in a row over a
  // waiting fetch, the fetch gets the next grant.
  function automatic grant_t f_grant(input logic inst_v, input logic data_v,
                                     input logic [SW-1:0] streak);
    grant_t g;
    g.data = data_v && !(inst_v && (streak == STREAK_CAP));
    g.inst = inst_v && !g.data;
    return g;
  endfunction

  function automatic logic [SW-1:0] f_streak_inc(input logic [SW-1:0] s);
    return (s == STREAK_CAP) ? STREAK_CAP : s + SW'(1);
  endfunction

  // Grants only in IDLE and never while reset is asserted.
  always_comb begin
    w_gnt = '0;
    if (reset && (r_state == ST_IDLE))
      w_gnt = f_grant(io_arb.inst_req_valid, io_arb.data_req_valid, r_streak);
  end

  // Route the read response to the owner of the outstanding read only.
  always_comb begin
    w_rd_rdy    = 1'b0;
    w_inst_rvld = 1'b0;
    w_data_rvld = 1'b0;
    if (r_state == ST_RD_RESP) begin
      if (r_owner == OWNER_DATA) begin
        w_data_rvld = io_arb.Read_data_Valid;
        w_rd_rdy    = io_arb.data_rdata_ready;
      end else begin
        w_inst_rvld = io_arb.Read_data_Valid;
        w_rd_rdy    = io_arb.inst_rdata_ready;
      end
    end
  end

  assign io_arb.inst_req_ready   = w_gnt.inst;
  assign io_arb.data_req_ready   = w_gnt.data;
  assign io_arb.inst_rdata       = io_arb.Read_data;
  assign io_arb.data_rdata       = io_arb.Read_data;
  assign io_arb.inst_rdata_valid = w_inst_rvld;
  assign io_arb.data_rdata_valid = w_data_rvld;
  assign io_arb.Read_data_Ready  = w_rd_rdy;
  assign io_arb.MemRead          = (r_state == ST_RD_REQ);
  assign io_arb.MemWrite         = (r_state == ST_WR_REQ);
  assign io_arb.Address          = r_addr;
  assign io_arb.Write_data       = r_wdata;
  assign io_arb.Write_strb       = r_wstrb;

  // Next-state: grant, hold the request until memory accepts, then wait for read data.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt.data)      w_state_nxt = io_arb.data_we ? ST_WR_REQ : ST_RD_REQ;
        else if (w_gnt.inst) w_state_nxt = ST_RD_REQ;
      end
      ST_RD_REQ:  if (io_arb.Mem_Req_Ready) w_state_nxt = ST_RD_RESP;
      ST_WR_REQ:  if (io_arb.Mem_Req_Ready) w_state_nxt = ST_IDLE;
      ST_RD_RESP: if (io_arb.Read_data_Valid && w_rd_rdy) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Capture the granted request and track the data-over-fetch streak.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner  <= OWNER_INST;
      r_streak <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else if (w_gnt.data) begin
      r_owner  <= OWNER_DATA;
      r_addr   <= io_arb.data_addr;
      r_wdata  <= io_arb.data_wdata;
      r_wstrb  <= io_arb.data_wstrb;
      r_streak <= io_arb.inst_req_valid ? f_streak_inc(r_streak) : '0;
    end else if (w_gnt.inst) begin
      r_owner  <= OWNER_INST;
      r_addr   <= io_arb.inst_addr;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_streak <= '0;
    end
  end

endmodule
